// File: rtl/esm_pkg.sv
// esm_pkg -- shared definitions for the ESM instruction window and core.
//   INSTR_W / BS : default instruction width and window depth
//   idx_w()      : index width for an n-entry structure (min 1 bit)
//   IDX_W/OCC_W  : index and occupancy widths for the default depth
//   entry_t      : one window entry (valid bit plus instruction word)
package esm_pkg;

  localparam int INSTR_W = 32;
  localparam int BS      = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_w(BS);
  localparam int OCC_W = IDX_W + 1;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
  } entry_t;

endpackage

// File: rtl/esm_free_slot_finder.sv
// esm_free_slot_finder -- lowest-index priority encoder over a free mask.
//   i_free_mask : bit i set = slot i is free
//   o_slot      : lowest-numbered free slot (0 when none is free)
//   o_any_free  : at least one slot is free
// Purely combinational.
module esm_free_slot_finder
  import esm_pkg::*;
#(
  parameter int N = BS
) (
  input  logic [N-1:0]        i_free_mask,
  output logic [idx_w(N)-1:0] o_slot,
  output logic                o_any_free
);

  always_comb begin
    o_slot     = '0;
    o_any_free = |i_free_mask;
    // Walk downward so the last hit, i.e. the lowest index, wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_free_mask[i]) o_slot = idx_w(N)'(i);
    end
  end

endmodule

// File: rtl/esm_instr_window.sv
// esm_instr_window -- instruction window feeding the ESM core.
//   clk, rst            : clock, synchronous active-high reset
//   flush               : invalidate all entries
//   fetch_valid/_instr  : fetch offer; fetch_ready = a free entry exists
//   buffer_index        : free-running scan pointer; Instr_out = entry there
//   valid_entries       : occupancy vector, bit 0 (MSB) = entry 0
//   issue_req/_index    : core selects an entry to issue
//   issue_valid/_instr  : registered issued instruction (1-cycle latency)
//   issue_err           : one-cycle pulse when issue_req names an empty entry
//   occupancy           : number of valid entries
module esm_instr_window
  import esm_pkg::*;
#(
  parameter int Instruction_word_size = INSTR_W,
  parameter int bs                    = BS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             fetch_valid,
  input  logic [Instruction_word_size-1:0] fetch_instr,
  output logic                             fetch_ready,
  output logic [$clog2(bs)-1:0]            buffer_index,
  output logic [Instruction_word_size-1:0] Instr_out,
  output logic [0:bs-1]                    valid_entries,
  input  logic                             issue_req,
  input  logic [$clog2(bs)-1:0]            issue_index,
  output logic                             issue_valid,
  output logic [Instruction_word_size-1:0] issue_instr,
  output logic                             issue_err,
  output logic [$clog2(bs):0]              occupancy
);

  localparam int WIN_IDX_W = idx_w(bs);
  localparam int WIN_OCC_W = WIN_IDX_W + 1;

  logic [Instruction_word_size-1:0] r_mem [bs];
  logic [0:bs-1]                    r_valid;
  logic [WIN_IDX_W-1:0]             r_scan;
  logic [WIN_OCC_W-1:0]             r_occ;
  logic                             r_issue_valid;
  logic [Instruction_word_size-1:0] r_issue_instr;
  logic                             r_issue_err;

  logic [bs-1:0]        w_free;
  logic [WIN_IDX_W-1:0] w_slot;
  logic                 w_any_free;
  logic                 w_fill;
  logic                 w_issue_ok;
  logic                 w_issue_bad;
  logic [0:bs-1]        w_valid_nxt;

  // Map the MSB-first valid vector onto an LSB-first free mask.
  always_comb begin
    for (int i = 0; i < bs; i++) w_free[i] = ~r_valid[i];
  end

  esm_free_slot_finder #(.N(bs)) u_free_slot (
    .i_free_mask (w_free),
    .o_slot      (w_slot),
    .o_any_free  (w_any_free)
  );

  assign fetch_ready = (r_occ != WIN_OCC_W'(bs));
  assign w_fill      = fetch_valid && fetch_ready && w_any_free;
  assign w_issue_ok  = issue_req &&  r_valid[issue_index];
  assign w_issue_bad = issue_req && !r_valid[issue_index];

  // The fill slot comes from pre-edge state, so it can never equal the
  // slot being issued this cycle; the freed slot is only reusable next cycle.
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_fill)     w_valid_nxt[w_slot]      = 1'b1;
    if (w_issue_ok) w_valid_nxt[issue_index] = 1'b0;
  end

  // NOTE: entry storage has no reset; the valid bits alone define contents,
  // which keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_fill) r_mem[w_slot] <= fetch_instr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid       <= '0;
      r_scan        <= '0;
      r_occ         <= '0;
      r_issue_valid <= 1'b0;
      r_issue_err   <= 1'b0;
      r_issue_instr <= '0;
    end else begin
      r_scan <= r_scan + 1'b1;
      if (flush) begin
        r_valid       <= '0;
        r_occ         <= '0;
        r_issue_valid <= 1'b0;
        r_issue_err   <= 1'b0;
      end else begin
        r_valid       <= w_valid_nxt;
        r_occ         <= r_occ + WIN_OCC_W'(w_fill) - WIN_OCC_W'(w_issue_ok);
        r_issue_valid <= w_issue_ok;
        r_issue_err   <= w_issue_bad;
        if (w_issue_ok) r_issue_instr <= r_mem[issue_index];
      end
    end
  end

  assign buffer_index  = r_scan;
  assign Instr_out     = r_mem[r_scan];
  assign valid_entries = r_valid;
  assign occupancy     = r_occ;
  assign issue_valid   = r_issue_valid;
  assign issue_instr   = r_issue_instr;
  assign issue_err     = r_issue_err;

  // Occupancy counter must track the valid vector exactly.
  always @(posedge clk) begin
    if (!rst) assert (WIN_OCC_W'($countones(r_valid)) == r_occ);
  end

endmodule

// File: tb/tb_esm_instr_window.sv
module tb_esm_instr_window;

  logic        clk = 1'b0;
  logic        rst, flush, fetch_valid, issue_req;
  logic [31:0] fetch_instr;
  logic [3:0]  issue_index;
  logic        fetch_ready, issue_valid, issue_err;
  logic [3:0]  buffer_index;
  logic [31:0] Instr_out, issue_instr;
  logic [0:15] valid_entries;
  logic [4:0]  occupancy;

  esm_instr_window dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_ready(fetch_ready),
    .buffer_index(buffer_index), .Instr_out(Instr_out), .valid_entries(valid_entries),
    .issue_req(issue_req), .issue_index(issue_index),
    .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_err(issue_err),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model of the window state.
  logic [0:15] m_valid = '0;
  logic [31:0] m_mem [16];
  int          m_occ   = 0;
  logic [3:0]  exp_idx = '0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model with the current inputs, clock one edge, then compare.
  task automatic tick();
    int slot;
    slot    = -1;
    exp_err = 1'b0;
    if (rst) begin
      m_valid = '0;
      exp_idx = '0;
      exp_q.delete();
    end else begin
      exp_idx = exp_idx + 4'd1;
      if (flush) begin
        m_valid = '0;
      end else begin
        if (fetch_valid && m_occ != 16) begin
          for (int i = 15; i >= 0; i--) if (!m_valid[i]) slot = i;
        end
        if (issue_req) begin
          if (m_valid[issue_index]) begin
            exp_q.push_back(m_mem[issue_index]);
            m_valid[issue_index] = 1'b0;
          end else begin
            exp_err = 1'b1;
          end
        end
        if (slot >= 0) begin
          m_valid[slot] = 1'b1;
          m_mem[slot]   = fetch_instr;
        end
      end
    end
    m_occ = $countones(m_valid);
    @(posedge clk);
    #1;
    check("valid_entries", 64'(valid_entries), 64'(m_valid));
    check("occupancy", 64'(occupancy), 64'(m_occ));
    check("buffer_index", 64'(buffer_index), 64'(exp_idx));
    check("issue_err", 64'(issue_err), 64'(exp_err));
    check("fetch_ready", 64'(fetch_ready), 64'(m_occ != 16));
    if (m_valid[buffer_index]) check("instr_out", 64'(Instr_out), 64'(m_mem[buffer_index]));
    if (exp_q.size() > 0) begin
      check("issue_valid", 64'(issue_valid), 64'd1);
      check("issue_instr", 64'(issue_instr), 64'(exp_q.pop_front()));
    end else begin
      check("issue_valid_idle", 64'(issue_valid), 64'd0);
    end
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    fetch_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      fetch_instr = base + 32'(i);
      tick();
    end
    fetch_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_instr = '0;
    issue_req = 1'b0; issue_index = '0;
    tick();
    tick();
    check("rst_issue_instr", 64'(issue_instr), 64'd0);
    check("rst_valid", 64'(valid_entries), 64'd0);
    check("rst_index", 64'(buffer_index), 64'd0);
    rst = 1'b0;

    // Free-running scan wraps 15 -> 0.
    repeat (20) tick();
    check("scan_wrap", 64'(buffer_index), 64'd4);

    // Issue into an empty window.
    issue_req = 1'b1; issue_index = 4'd0;
    tick();
    issue_req = 1'b0;
    check("empty_issue_err", 64'(issue_err), 64'd1);
    tick();
    check("err_one_cycle", 64'(issue_err), 64'd0);

    // Fill all 16 entries, then offer a 17th.
    fill(16, 32'h100);
    check("full_valid", 64'(valid_entries), 64'hFFFF);
    check("full_occ", 64'(occupancy), 64'd16);
    check("full_ready", 64'(fetch_ready), 64'd0);
    fetch_valid = 1'b1; fetch_instr = 32'hDEAD;
    tick();
    fetch_valid = 1'b0;
    check("full_ignore_valid", 64'(valid_entries), 64'hFFFF);
    check("full_ignore_occ", 64'(occupancy), 64'd16);

    // Scan a full window; Instr_out checked every cycle.
    repeat (16) tick();

    // Issue entry 5 from a full window, then refill it.
    issue_req = 1'b1; issue_index = 4'd5;
    tick();
    issue_req = 1'b0;
    check("iss5_valid", 64'(issue_valid), 64'd1);
    check("iss5_instr", 64'(issue_instr), 64'h105);
    check("iss5_bit", 64'(valid_entries[5]), 64'd0);
    check("iss5_occ", 64'(occupancy), 64'd15);
    fill(1, 32'hABC);
    check("refill_valid", 64'(valid_entries), 64'hFFFF);
    issue_req = 1'b1; issue_index = 4'd5;
    tick();
    issue_req = 1'b0;
    check("refill_instr", 64'(issue_instr), 64'hABC);

    // Simultaneous fill and issue at occupancy 3.
    do_reset();
    fill(3, 32'h300);
    fetch_valid = 1'b1; fetch_instr = 32'h200;
    issue_req = 1'b1; issue_index = 4'd1;
    tick();
    fetch_valid = 1'b0; issue_req = 1'b0;
    check("sim_valid", 64'(valid_entries), 64'hB000);
    check("sim_occ", 64'(occupancy), 64'd3);
    check("sim_instr", 64'(issue_instr), 64'h301);
    issue_req = 1'b1; issue_index = 4'd3;
    tick();
    issue_req = 1'b0;
    check("sim_entry3", 64'(issue_instr), 64'h200);

    // Issue of an empty entry in a partly filled window.
    issue_req = 1'b1; issue_index = 4'd9;
    tick();
    issue_req = 1'b0;
    check("iss9_err", 64'(issue_err), 64'd1);
    check("iss9_valid", 64'(valid_entries), 64'hA000);
    tick();
    check("iss9_err_drop", 64'(issue_err), 64'd0);

    // Flush beats fill and issue.
    do_reset();
    fill(8, 32'h400);
    check("occ8", 64'(occupancy), 64'd8);
    flush = 1'b1; fetch_valid = 1'b1; fetch_instr = 32'h555;
    issue_req = 1'b1; issue_index = 4'd2;
    tick();
    flush = 1'b0; fetch_valid = 1'b0; issue_req = 1'b0;
    check("flush_valid", 64'(valid_entries), 64'd0);
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_issue_valid", 64'(issue_valid), 64'd0);

    // Reset mid-stream with a pending issue and fill.
    fill(2, 32'h600);
    issue_req = 1'b1; issue_index = 4'd0;
    tick();
    check("pre_rst_instr", 64'(issue_instr), 64'h600);
    fetch_valid = 1'b1; fetch_instr = 32'h777;
    issue_req = 1'b1; issue_index = 4'd1;
    rst = 1'b1;
    tick();
    rst = 1'b0; fetch_valid = 1'b0; issue_req = 1'b0;
    check("mid_rst_valid", 64'(valid_entries), 64'd0);
    check("mid_rst_occ", 64'(occupancy), 64'd0);
    check("mid_rst_index", 64'(buffer_index), 64'd0);
    check("mid_rst_issue_valid", 64'(issue_valid), 64'd0);
    check("mid_rst_instr", 64'(issue_instr), 64'd0);
    tick();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/esm_instr_window.md
Name: esm_instr_window

Overview:
- Instruction window that sits directly upstream of the ESM core.
- Holds up to bs fetched instructions. Each cycle it presents one entry, selected by a free-running scan pointer, to the core's dependence analyser.
- Exports the per-entry valid vector to the core.
- Takes the core's selected index back and issues that entry, freeing its slot.

Parameters:
- Instruction_word_size, 32, width of one instruction word.
- bs, 16, number of window entries. Must be a power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  invalidate all entries.
- fetch_valid  in  1  fetch offers an instruction.
- fetch_instr  in  Instruction_word_size  offered instruction.
- fetch_ready  out  1  a free entry exists (combinational from valid state).
- buffer_index  out  $clog2(bs)  scan pointer, presented to the core.
- Instr_out  out  Instruction_word_size  entry at buffer_index (combinational read).
- valid_entries  out  [0:bs-1]  bit i = entry i occupied. Bit 0 is the MSB.
- issue_req  in  1  core's valid_count: an independent instruction was selected.
- issue_index  in  $clog2(bs)  core's next_buffer_index.
- issue_valid  out  1  registered: issue_instr is valid this cycle.
- issue_instr  out  Instruction_word_size  registered issued instruction.
- issue_err  out  1  one-cycle pulse: issue_req named an empty entry.
- occupancy  out  $clog2(bs)+1  number of valid entries.

Behaviour:
- Reset (rst=1 at an edge):
  - valid_entries=0, buffer_index=0, occupancy=0.
  - issue_valid=0, issue_err=0, issue_instr=0.
  - Entry storage is not cleared.
  - Reset mid-operation discards all state the same way; no partial issue survives.
- fetch_ready = (occupancy != bs).
- Fill:
  - On fetch_valid && fetch_ready, fetch_instr is written to the lowest-numbered free entry.
  - That valid bit is set at the edge.
  - The free entry is computed from pre-edge valid state.
- Scan pointer:
  - Increments by 1 every cycle when not in reset.
  - Wraps from bs-1 to 0 via natural modulo; no special case.
  - Scans empty entries too; the core masks them using valid_entries.
- Issue:
  - On issue_req && valid_entries[issue_index]: issue_instr <= entry[issue_index], issue_valid <= 1, valid bit cleared at the same edge.
  - Latency is 1 cycle from issue_req to issue_valid.
  - On issue_req with an empty entry: no state change, issue_err <= 1 for one cycle, issue_valid <= 0.
  - Without issue_req: issue_valid <= 0; issue_instr holds its last value.
- Simultaneous fill + issue:
  - Both take effect at the same edge; occupancy is unchanged.
  - The slot freed by the issue is not reusable by the fill in that same cycle (no bypass).
  - The fill target is always a free entry, so it never collides with the issue target.
- Full window: fetch_ready=0; fetch_valid is ignored (no write, no error).
- Empty window: issue_req raises issue_err.
- Flush:
  - Priority over fill and issue in the same cycle: valid_entries <= 0, occupancy <= 0, issue_valid <= 0.
  - buffer_index keeps counting.
- occupancy:
  - Registered.
  - Updated as +1 on a fill, -1 on a valid issue, net 0 when both occur.
  - Must always equal the popcount of valid_entries; an assertion checks this.

Decomposition:
- Shared package esm_pkg:
  - Index width function/constant IDX_W = $clog2(bs).
  - OCC_W = IDX_W+1.
  - Window-entry type (instruction word plus valid bit).
- One sub-module, esm_free_slot_finder:
  - Parameterised lowest-index priority encoder over ~valid_entries.
  - Outputs the slot index and an any_free flag.
  - Purely combinational; reusable by the core's IIM.

Test Plan:
- Reset, then 16 back-to-back fetches of 0x100+i -> entries 0..15 filled in order; after the 16th edge valid_entries=16'hFFFF, occupancy=16, fetch_ready=0. A 17th fetch_valid is ignored.
- Full window, issue_req with issue_index=5 -> next cycle issue_valid=1, issue_instr=0x105, valid bit 5 clear, occupancy=15. A following fetch 0xABC lands in entry 5.
- Free-running scan over 20 cycles after reset -> buffer_index runs 0..15,0..3. Instr_out always equals the entry at buffer_index.
- Occupancy 3 (entries 0..2), simultaneous fetch 0x200 and issue of index 1 -> 0x200 written to entry 3, entry 1 cleared, occupancy stays 3, issue_instr=entry1 value.
- issue_req with issue_index=9 on an empty entry -> issue_err=1 for exactly one cycle, issue_valid=0, valid_entries unchanged.
- Occupancy 8, flush together with fetch_valid and issue_req -> valid_entries=0, occupancy=0, issue_valid=0 next cycle. rst asserted mid-stream -> all outputs return to reset values at the next edge.
